// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_SRL = 3'd3,
        OP_SLL = 3'd4,
        OP_SRA = 3'd5,
        OP_MUL = 3'd6,
        OP_CMP = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_step.sv
// One iteration of the double-width shifter / shift-add multiplier.
module seq_alu_step
    import seq_alu_pkg::*;
#(
    parameter int REG_WIDTH = 9
) (
    input  logic [REG_WIDTH-1:0] hi_in,
    input  logic [REG_WIDTH-1:0] lo_in,
    input  op_e                  op,
    input  logic                 mul_lsb,
    input  logic [REG_WIDTH-1:0] mcand,
    output logic [REG_WIDTH-1:0] hi_out,
    output logic [REG_WIDTH-1:0] lo_out
);

    logic [REG_WIDTH:0] sum;

    always_comb begin
        sum    = {1'b0, hi_in} + (mul_lsb ? {1'b0, mcand} : '0);
        hi_out = hi_in;
        lo_out = lo_in;
        unique case (op)
            OP_SRL: {hi_out, lo_out} = {1'b0, hi_in, lo_in[REG_WIDTH-1:1]};
            OP_SRA: {hi_out, lo_out} = {hi_in[REG_WIDTH-1], hi_in, lo_in[REG_WIDTH-1:1]};
            OP_SLL: {hi_out, lo_out} = {hi_in[REG_WIDTH-2:0], lo_in, 1'b0};
            // Add's carry-out lands in the hi MSB as the pair shifts right.
            OP_MUL: {hi_out, lo_out} = {sum, lo_in[REG_WIDTH-1:1]};
            default: begin
                hi_out = hi_in;
                lo_out = lo_in;
            end
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake; shifts and multiply iterate one bit per edge.
//   state | meaning
//   IDLE  | waiting for start; single-cycle ops complete here
//   SHIFT | shifting {hi,lo} one bit per edge, cnt bits remaining
//   MUL   | shift-add multiply, cnt iterations remaining
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int REG_WIDTH = 9,
    parameter int OP_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [OP_WIDTH-1:0]  op,
    input  logic [REG_WIDTH-1:0] ra_in,
    input  logic [REG_WIDTH-1:0] rb_in,
    output logic                 busy,
    output logic                 done,
    output logic [REG_WIDTH-1:0] res_out,
    output logic [REG_WIDTH-1:0] car_out,
    output logic                 zero,
    output logic                 jump
);

    localparam int SHAMT_W = $clog2(REG_WIDTH + 1);

    state_e               state_q, state_d;
    logic [OP_WIDTH-1:0]  op_q, op_d;
    logic [REG_WIDTH-1:0] hi_q, hi_d;
    logic [REG_WIDTH-1:0] lo_q, lo_d;
    logic [REG_WIDTH-1:0] mcand_q, mcand_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [REG_WIDTH-1:0] res_q, res_d;
    logic [REG_WIDTH-1:0] car_q, car_d;
    logic                 jump_q, jump_d;
    logic                 done_q, done_d;

    logic [REG_WIDTH:0]   add_sum;
    logic [REG_WIDTH:0]   sub_diff;
    logic [SHAMT_W-1:0]   n_clamp;
    logic [REG_WIDTH-1:0] step_hi, step_lo;
    op_e                  step_op;

    assign step_op = op_e'(op_q[2:0]);

    seq_alu_step #(
        .REG_WIDTH (REG_WIDTH)
    ) u_step (
        .hi_in   (hi_q),
        .lo_in   (lo_q),
        .op      (step_op),
        .mul_lsb (lo_q[0]),
        .mcand   (mcand_q),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    always_comb begin
        add_sum  = {1'b0, ra_in} + {1'b0, rb_in};
        sub_diff = {1'b0, ra_in} - {1'b0, rb_in};
        if (rb_in >= REG_WIDTH'(REG_WIDTH)) begin
            n_clamp = SHAMT_W'(REG_WIDTH);
        end else begin
            n_clamp = SHAMT_W'(rb_in);
        end

        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        car_d   = car_q;
        jump_d  = jump_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    mcand_d = rb_in;
                    case (op)
                        OP_WIDTH'(OP_ADD): begin
                            res_d  = add_sum[REG_WIDTH-1:0];
                            car_d  = {{(REG_WIDTH-1){1'b0}}, add_sum[REG_WIDTH]};
                            jump_d = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_WIDTH'(OP_SUB): begin
                            res_d  = sub_diff[REG_WIDTH-1:0];
                            car_d  = {{(REG_WIDTH-1){1'b0}}, sub_diff[REG_WIDTH]};
                            jump_d = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_WIDTH'(OP_AND): begin
                            res_d  = ra_in & rb_in;
                            car_d  = '0;
                            jump_d = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_WIDTH'(OP_SRL), OP_WIDTH'(OP_SRA), OP_WIDTH'(OP_SLL): begin
                            if (n_clamp == '0) begin
                                res_d  = ra_in;
                                car_d  = '0;
                                jump_d = 1'b0;
                                done_d = 1'b1;
                            end else begin
                                // Right shifts run ra through hi into lo; SLL runs lo into hi.
                                if (op == OP_WIDTH'(OP_SLL)) begin
                                    hi_d = '0;
                                    lo_d = ra_in;
                                end else begin
                                    hi_d = ra_in;
                                    lo_d = '0;
                                end
                                cnt_d   = n_clamp;
                                state_d = SHIFT;
                            end
                        end
                        OP_WIDTH'(OP_MUL): begin
                            hi_d    = '0;
                            lo_d    = ra_in;
                            cnt_d   = SHAMT_W'(REG_WIDTH);
                            state_d = MUL;
                        end
                        OP_WIDTH'(OP_CMP): begin
                            res_d  = sub_diff[REG_WIDTH-1:0];
                            car_d  = '0;
                            jump_d = (ra_in == rb_in);
                            done_d = 1'b1;
                        end
                        default: begin
                            res_d  = '0;
                            car_d  = '0;
                            jump_d = 1'b0;
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT, MUL: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    if ((op_q == OP_WIDTH'(OP_SRL)) || (op_q == OP_WIDTH'(OP_SRA))) begin
                        res_d = step_hi;
                        car_d = step_lo;
                    end else begin
                        res_d = step_lo;
                        car_d = step_hi;
                    end
                    jump_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            car_q   <= '0;
            jump_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            car_q   <= car_d;
            jump_q  <= jump_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign res_out = res_q;
    assign car_out = car_q;
    assign zero    = (res_q == '0);
    assign jump    = jump_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at REG_WIDTH=9 with hand-computed expected results.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [8:0] ra_in;
    logic [8:0] rb_in;
    logic       busy;
    logic       done;
    logic [8:0] res_out;
    logic [8:0] car_out;
    logic       zero;
    logic       jump;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_n;
    int dn;

    seq_alu #(.REG_WIDTH(9), .OP_WIDTH(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .ra_in   (ra_in),
        .rb_in   (rb_in),
        .busy    (busy),
        .done    (done),
        .res_out (res_out),
        .car_out (car_out),
        .zero    (zero),
        .jump    (jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after an edge; the next edge is the accepting edge.
    task automatic start_op(input logic [2:0] o, input logic [8:0] a, input logic [8:0] b);
        start = 1'b1;
        op    = o;
        ra_in = a;
        rb_in = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int l, output int bn);
        l  = 1;
        bn = 0;
        while (!done && l < 40) begin
            if (busy) bn++;
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        ra_in = '0;
        rb_in = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", res_out, 0);
        chk("rst_car", car_out, 0);
        chk("rst_zero", zero, 1);
        chk("rst_jump", jump, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        start_op(OP_ADD, 9'd300, 9'd400);
        wait_done(lat, busy_n);
        chk("add_lat", lat, 1);
        chk("add_res", res_out, 188);
        chk("add_car", car_out, 1);
        chk("add_zero", zero, 0);
        chk("add_jump", jump, 0);
        @(posedge clk);
        #1;
        chk("add_done_pulse", done, 0);

        start_op(OP_SUB, 9'd3, 9'd5);
        wait_done(lat, busy_n);
        chk("sub_res", res_out, 510);
        chk("sub_borrow", car_out, 1);

        start_op(OP_AND, 9'h1AA, 9'h0F0);
        wait_done(lat, busy_n);
        chk("and_res", res_out, 160);
        chk("and_car", car_out, 0);

        start_op(OP_SRL, 9'd245, 9'd3);
        wait_done(lat, busy_n);
        chk("srl_lat", lat, 4);
        chk("srl_busy", busy_n, 3);
        chk("srl_res", res_out, 30);
        chk("srl_car", car_out, 320);
        chk("srl_busy_at_done", busy, 0);

        start_op(OP_SLL, 9'd3, 9'd8);
        wait_done(lat, busy_n);
        chk("sll_lat", lat, 9);
        chk("sll_res", res_out, 256);
        chk("sll_car", car_out, 1);

        start_op(OP_SRL, 9'd5, 9'd0);
        wait_done(lat, busy_n);
        chk("srl0_lat", lat, 1);
        chk("srl0_res", res_out, 5);
        chk("srl0_car", car_out, 0);

        start_op(OP_SRA, 9'd256, 9'd12);
        wait_done(lat, busy_n);
        chk("sra_lat", lat, 10);
        chk("sra_res", res_out, 511);
        chk("sra_car", car_out, 256);

        start_op(OP_CMP, 9'd77, 9'd77);
        wait_done(lat, busy_n);
        chk("cmpeq_res", res_out, 0);
        chk("cmpeq_zero", zero, 1);
        chk("cmpeq_jump", jump, 1);
        chk("cmpeq_car", car_out, 0);

        // MUL with an ADD start mid-flight that must be ignored.
        start_op(OP_MUL, 9'd25, 9'd30);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = OP_ADD;
        ra_in = 9'd1;
        rb_in = 9'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mul_ign_busy", busy, 1);
        chk("mul_ign_done", done, 0);
        chk("mul_hold_res", res_out, 0);
        chk("mul_hold_jump", jump, 1);
        wait_done(lat, busy_n);
        chk("mul_lat", lat + 4, 10);
        chk("mul_res", res_out, 238);
        chk("mul_car", car_out, 1);
        chk("mul_jump", jump, 0);
        chk("mul_busy_at_done", busy, 0);

        start_op(OP_ADD, 9'd1, 9'd2);
        chk("b2b_done", done, 1);
        chk("b2b_res", res_out, 3);

        start_op(OP_CMP, 9'd5, 9'd6);
        wait_done(lat, busy_n);
        chk("cmpne_res", res_out, 511);
        chk("cmpne_jump", jump, 0);
        chk("cmpne_zero", zero, 0);

        start_op(OP_MUL, 9'd25, 9'd30);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_res", res_out, 0);
        chk("mrst_car", car_out, 0);
        chk("mrst_zero", zero, 1);
        chk("mrst_jump", jump, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("mrst_no_done", dn, 0);

        start_op(OP_ADD, 9'd1, 9'd1);
        wait_done(lat, busy_n);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_res", res_out, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
